// File: rtl/pe_array_sequencer.sv
// Sequencer feeding a weight-stationary PE array: buffers weights plus ping-pong activation
// banks, replays them every period and tags psum results. Define PE_SEQ_RES_REG_EN to register res_* outputs.
module pe_array_sequencer #(
  parameter int ROW_LENGTH = 11,
  parameter int O_CH       = 6,
  parameter int WIDTH      = 14
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [7:0]       num_win_in,
  input  logic [26:0]      src_data_in,
  input  logic             src_valid_in,
  output logic             src_ready_out,
  output logic             arr_rst_n_out,
  output logic [26:0]      arr_data_out,
  input  logic [WIDTH-1:0] psum_in,
  output logic [WIDTH-1:0] res_data_out,
  output logic [2:0]       res_ch_out,
  output logic [7:0]       res_win_out,
  output logic             res_valid_out,
  output logic             done_out,
  output logic             err_out
);

  localparam int W_WORDS = O_CH * ROW_LENGTH;
  localparam int LOAD    = W_WORDS + ROW_LENGTH;
  localparam int CNT_W   = $clog2(LOAD);
  localparam int WI_W    = $clog2(W_WORDS);
  localparam int AI_W    = $clog2(ROW_LENGTH);
  localparam int FILL_W  = $clog2(ROW_LENGTH + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOAD - 1);
  localparam logic [CNT_W-1:0]  CNT_ACT   = CNT_W'(W_WORDS);
  localparam logic [CNT_W-1:0]  RES_FIRST = CNT_W'(2);
  localparam logic [CNT_W-1:0]  RES_LAST  = CNT_W'(O_CH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ROW_LENGTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          period_q, period_d;
  logic [7:0]          nwin_q, nwin_d;
  logic                bank_q, bank_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [26:0]         wgt_mem [W_WORDS];
  logic [26:0]         act_mem [2][ROW_LENGTH];

  logic                wgt_we;
  logic [WI_W-1:0]     wgt_waddr;
  logic                act_we;
  logic                act_wbank;
  logic [AI_W-1:0]     act_waddr;
  logic [AI_W-1:0]     act_idx;
  logic                more_win;
  logic                accept;
  logic                bank_full;

  logic                res_valid_d;
  logic [WIDTH-1:0]    res_data_d;
  logic [2:0]          res_ch_d;
  logic [7:0]          res_win_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      nwin_q   <= 8'd1;
      bank_q   <= 1'b0;
      fill_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      nwin_q   <= nwin_d;
      bank_q   <= bank_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wgt_we) wgt_mem[wgt_waddr] <= src_data_in;
    if (act_we) act_mem[act_wbank][act_waddr] <= src_data_in;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    nwin_d        = nwin_q;
    bank_d        = bank_q;
    fill_d        = fill_q;
    err_d         = err_q;
    done_d        = 1'b0;
    src_ready_out = 1'b0;
    arr_rst_n_out = 1'b0;
    arr_data_out  = '0;
    wgt_we        = 1'b0;
    wgt_waddr     = WI_W'(cnt_q);
    act_we        = 1'b0;
    act_wbank     = ~bank_q;
    act_waddr     = fill_q[AI_W-1:0];
    act_idx       = AI_W'(cnt_q - CNT_ACT);
    accept        = 1'b0;
    bank_full     = 1'b0;
    // another window still follows the one currently replayed
    more_win      = ({1'b0, period_q} + 9'd1) < {1'b0, nwin_q};

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
          nwin_d  = (num_win_in == 8'd0) ? 8'd1 : num_win_in;
        end
      end

      FILL: begin
        src_ready_out = 1'b1;
        if (src_valid_in) begin
          if (cnt_q < CNT_ACT) begin
            wgt_we = 1'b1;
          end else begin
            act_we    = 1'b1;
            act_wbank = 1'b0;
            act_waddr = act_idx;
          end
          if (cnt_q == CNT_LAST) begin
            state_d  = RUN;
            cnt_d    = '0;
            period_d = '0;
            bank_d   = 1'b0;
            fill_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RUN: begin
        arr_rst_n_out = 1'b1;
        arr_data_out  = (cnt_q < CNT_ACT) ? wgt_mem[WI_W'(cnt_q)] : act_mem[bank_q][act_idx];
        src_ready_out = more_win && (fill_q != FILL_FULL);
        accept        = src_ready_out && src_valid_in;
        if (accept) begin
          act_we = 1'b1;
          fill_d = fill_q + FILL_W'(1);
        end
        // a word landing on the final cycle still counts toward the swap
        bank_full = (fill_d == FILL_FULL);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!more_win) begin
            state_d  = DRAIN;
            period_d = period_q + 8'd1;
          end else if (bank_full) begin
            period_d = period_q + 8'd1;
            bank_d   = ~bank_q;
            fill_d   = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        arr_rst_n_out = 1'b1;
        if (cnt_q < CNT_ACT) arr_data_out = wgt_mem[WI_W'(cnt_q)];
        if (cnt_q == RES_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // psum for the previous window emerges a fixed number of cycles into each period
  always_comb begin
    res_valid_d = ((state_q == RUN) || (state_q == DRAIN)) && (period_q != 8'd0) &&
                  (cnt_q >= RES_FIRST) && (cnt_q <= RES_LAST);
    res_data_d  = '0;
    res_ch_d    = '0;
    res_win_d   = '0;
    if (res_valid_d) begin
      res_data_d = psum_in;
      res_ch_d   = 3'(cnt_q - RES_FIRST);
      res_win_d  = period_q - 8'd1;
    end
  end

  assign err_out = err_q;

`ifdef PE_SEQ_RES_REG_EN
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [2:0]       res_ch_q;
  logic [7:0]       res_win_q;
  logic             done_dly_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_win_q   <= '0;
      done_dly_q  <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      res_win_q   <= res_win_d;
      done_dly_q  <= done_q;
    end
  end

  assign res_valid_out = res_valid_q;
  assign res_data_out  = res_data_q;
  assign res_ch_out    = res_ch_q;
  assign res_win_out   = res_win_q;
  assign done_out      = done_dly_q;
`else
  assign res_valid_out = res_valid_d;
  assign res_data_out  = res_data_d;
  assign res_ch_out    = res_ch_d;
  assign res_win_out   = res_win_d;
  assign done_out      = done_q;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomized bench for pe_array_sequencer against a word-count / window-queue reference model.
module tb_pe_array_sequencer;
  localparam int WIDTH = 14;
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_RUN = 2, PH_DRAIN = 3;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             start_in = 1'b0;
  logic [7:0]       num_win_in = '0;
  logic [26:0]      src_data_in = '0;
  logic             src_valid_in = 1'b0;
  logic             src_ready_out;
  logic             arr_rst_n_out;
  logic [26:0]      arr_data_out;
  logic [WIDTH-1:0] psum_in = '0;
  logic [WIDTH-1:0] res_data_out;
  logic [2:0]       res_ch_out;
  logic [7:0]       res_win_out;
  logic             res_valid_out;
  logic             done_out;
  logic             err_out;

  always #5 clk_in = ~clk_in;

  pe_array_sequencer #(.ROW_LENGTH(11), .O_CH(6), .WIDTH(WIDTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .num_win_in(num_win_in),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
    .arr_rst_n_out(arr_rst_n_out), .arr_data_out(arr_data_out), .psum_in(psum_in),
    .res_data_out(res_data_out), .res_ch_out(res_ch_out), .res_win_out(res_win_out),
    .res_valid_out(res_valid_out), .done_out(done_out), .err_out(err_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: job phase, words accepted so far, windows stored by window number
  int m_ph, m_cnt, m_period, m_nwin, m_acc;
  logic m_err, m_done, m_done2;
  logic [26:0] m_wgt [66];
  logic [26:0] m_act [256][11];

  logic e_ready, e_rst_n, e_valid, e_done, c_valid, p_valid;
  logic [26:0] e_data;
  logic [WIDTH-1:0] e_rdata, c_data, p_data;
  int e_ch, e_win, c_ch, c_win, p_ch, p_win;
  int res_seen, done_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_cnt = 0; m_period = 0; m_nwin = 1; m_acc = 0;
    m_err = 1'b0; m_done = 1'b0; m_done2 = 1'b0;
    p_valid = 1'b0; p_data = '0; p_ch = 0; p_win = 0;
  endtask

  task automatic model_expect();
    int lim;
    lim = (m_nwin < m_period + 2) ? m_nwin : m_period + 2;
    e_rst_n = (m_ph == PH_RUN) || (m_ph == PH_DRAIN);
    e_ready = (m_ph == PH_FILL) || ((m_ph == PH_RUN) && (m_acc < 66 + 11 * lim));
    e_data = '0;
    if (m_ph == PH_RUN) e_data = (m_cnt < 66) ? m_wgt[m_cnt] : m_act[m_period][m_cnt - 66];
    if (m_ph == PH_DRAIN && m_cnt < 66) e_data = m_wgt[m_cnt];
    c_valid = e_rst_n && (m_period >= 1) && (m_cnt >= 2) && (m_cnt <= 7);
    c_data = psum_in;
    c_ch = m_cnt - 2;
    c_win = m_period - 1;
`ifdef PE_SEQ_RES_REG_EN
    e_valid = p_valid; e_rdata = p_data; e_ch = p_ch; e_win = p_win; e_done = m_done2;
`else
    e_valid = c_valid; e_rdata = c_data; e_ch = c_ch; e_win = c_win; e_done = m_done;
`endif
  endtask

  task automatic model_step(input logic st, input logic vld, input logic [26:0] dat);
    logic acc;
    acc = vld && e_ready;
    p_valid = c_valid; p_data = c_data; p_ch = c_ch; p_win = c_win;
    m_done2 = m_done;
    m_done = (m_ph == PH_DRAIN) && (m_cnt == 7);
    if (acc) begin
      if (m_acc < 66) m_wgt[m_acc] = dat;
      else m_act[(m_acc - 66) / 11][(m_acc - 66) % 11] = dat;
      m_acc++;
    end
    case (m_ph)
      PH_IDLE: if (st) begin
        m_ph = PH_FILL; m_acc = 0; m_err = 1'b0;
        m_nwin = (num_win_in == 8'd0) ? 1 : int'(num_win_in);
      end
      PH_FILL: if (acc && m_acc == 77) begin
        m_ph = PH_RUN; m_cnt = 0; m_period = 0;
      end
      PH_RUN: begin
        if (m_cnt == 76) begin
          m_cnt = 0;
          if (m_period == m_nwin - 1) begin
            m_ph = PH_DRAIN; m_period++;
          end else if (m_acc >= 66 + 11 * (m_period + 2)) begin
            m_period++;
          end else begin
            m_ph = PH_IDLE; m_err = 1'b1;
          end
        end else m_cnt++;
      end
      default: begin
        if (m_cnt == 7) m_ph = PH_IDLE;
        else m_cnt++;
      end
    endcase
  endtask

  task automatic compare_outputs();
    check("src_ready", src_ready_out, e_ready);
    check("arr_rst_n", arr_rst_n_out, e_rst_n);
    check("arr_data", arr_data_out, e_data);
    check("res_valid", res_valid_out, e_valid);
    if (e_valid) begin
      check("res_data", res_data_out, e_rdata);
      check("res_ch", res_ch_out, e_ch);
      check("res_win", res_win_out, e_win);
    end
    check("done", done_out, e_done);
    check("err", err_out, m_err);
  endtask

  task automatic tick(input logic st, input logic vld, input logic [26:0] dat);
    @(negedge clk_in);
    start_in = st; src_valid_in = vld; src_data_in = dat;
    psum_in = WIDTH'($urandom);
    #1;
    model_expect();
    compare_outputs();
    if (res_valid_out) begin
      check("res_seq", int'(res_win_out) * 6 + int'(res_ch_out), res_seen);
      res_seen++;
    end
    if (done_out) done_seen++;
    model_step(st, vld, dat);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b1; start_in = 1'b0; src_valid_in = 1'b0;
    model_reset();
    #1;
    model_expect();
    compare_outputs();
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    model_expect();
    compare_outputs();
    model_step(1'b0, 1'b0, '0);
  endtask

  // mode: 0 random data, 1 index data, 2 withhold next window, 3 idle noise + stray starts, 4 reset mid-run
  task automatic run_job(input int nwin, input int prob, input int mode);
    int guard, limit, eff;
    logic st, vld;
    logic [26:0] dat;
    guard = 0;
    limit = 2000 + 80 * (nwin + 2);
    eff = (nwin == 0) ? 1 : nwin;
    res_seen = 0; done_seen = 0;
    num_win_in = 8'(nwin);
    if (mode == 3) for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 27'($urandom));
    tick(1'b1, 1'b0, '0);
    @(posedge clk_in); #1;
    num_win_in = 8'($urandom);
    while (m_ph != PH_IDLE && guard < limit) begin
      if (mode == 4 && m_ph == PH_RUN && m_period == 1 && m_cnt == 40) begin
        apply_reset();
        break;
      end
      st = (mode == 3) && (guard == 10 || guard == 150);
      vld = ($urandom_range(99) < prob);
      if (mode == 2 && m_ph == PH_RUN) vld = (m_cnt == 76);
      if (mode == 1) dat = (m_acc < 66) ? 27'(m_acc) : 27'(100 + (m_acc - 66) % 11);
      else dat = 27'($urandom);
      tick(st, vld, dat);
      guard++;
    end
    check("job_bound", guard < limit, 1);
    if (mode == 4) begin
      res_seen = 0; done_seen = 0;
      for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, '0);
      check("post_rst_res", res_seen, 0);
      check("post_rst_done", done_seen, 0);
    end else begin
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
      if (mode == 2 || m_err) begin
        check("err_flag", err_out, 1);
        check("err_arr_rst_n", arr_rst_n_out, 0);
        check("err_res_count", res_seen, 6 * m_period);
        check("err_done_count", done_seen, 0);
      end else begin
        check("res_count", res_seen, 6 * eff);
        check("done_count", done_seen, 1);
        check("err_clear", err_out, 0);
      end
    end
  endtask

  initial begin
    int probs [4];
    probs = '{100, 85, 50, 20};
    model_reset();
    apply_reset();
    run_job(1, 100, 1);
    run_job(3, 100, 0);
    run_job(2, 100, 2);
    run_job(2, 100, 3);
    run_job(3, 100, 4);
    run_job(0, 100, 0);
    for (int j = 0; j < 8; j++) run_job($urandom_range(0, 5), probs[$urandom_range(0, 3)], 0);
    run_job(255, 100, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
